alu_share_arbiter: RTL and testbench

//   Shares one combinational ALU (3-bit ALUControl: 000 add, 001 sub, 010 and, 011 or)

---
 rtl/alu_share_if.sv | 51 +++++
 rtl/alu_share_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_if.sv
// Bundle of requester, response and ALU-side signals for the shared-ALU arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface alu_share_if #(
  parameter int WIDTH = 32,
  parameter int CTRLW = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [CTRLW-1:0] req0_ctrl;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [CTRLW-1:0] req1_ctrl;

  logic             rsp0_valid;
  logic             rsp1_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;

  logic [WIDTH-1:0] alu_srca;
  logic [WIDTH-1:0] alu_srcb;
  logic [CTRLW-1:0] alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    input  rsp_ready, alu_result, alu_zero,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    output alu_srca, alu_srcb, alu_ctrl, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    output rsp_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    input  alu_srca, alu_srcb, alu_ctrl, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin (or fixed-priority) front end for one shared ALU.
// Each op runs IDLE -> EXEC -> RESP; illegal control codes skip EXEC.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int CTRLW   = 3,
  parameter bit FIXPRIO = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  alu_share_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] srca_q, srca_d;
  logic [WIDTH-1:0] srcb_q, srcb_d;
  logic [CTRLW-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             rsp0_q, rsp0_d;
  logic             rsp1_q, rsp1_d;
  logic             busy_q, busy_d;

  logic             gnt0, gnt1, acc0, acc1;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [CTRLW-1:0] sel_ctrl;

  // A tie goes to req0 unless req0 was the last requester served.
  assign gnt0 = bus.req0_valid & (~bus.req1_valid | FIXPRIO | last_grant_q);
  assign gnt1 = bus.req1_valid & ~gnt0;
  assign acc0 = reset & (state_q == IDLE) & gnt0;
  assign acc1 = reset & (state_q == IDLE) & gnt1;

  assign sel_a    = acc1 ? bus.req1_a    : bus.req0_a;
  assign sel_b    = acc1 ? bus.req1_b    : bus.req0_b;
  assign sel_ctrl = acc1 ? bus.req1_ctrl : bus.req0_ctrl;

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path infers a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    srca_d       = srca_q;
    srcb_d       = srcb_q;
    ctrl_d       = ctrl_q;
    result_d     = result_q;
    zero_d       = zero_q;
    err_d        = err_q;
    rsp0_d       = rsp0_q;
    rsp1_d       = rsp1_q;

    unique case (state_q)
      IDLE: begin
        if (acc0 | acc1) begin
          owner_d      = acc1;
          last_grant_d = acc1;
          if (sel_ctrl[CTRLW-1]) begin
            state_d  = RESP;
            result_d = '0;
            zero_d   = 1'b1;
            err_d    = 1'b1;
            rsp0_d   = ~acc1;
            rsp1_d   = acc1;
          end else begin
            state_d = EXEC;
            srca_d  = sel_a;
            srcb_d  = sel_b;
            ctrl_d  = sel_ctrl;
          end
        end
      end
      EXEC: begin
        state_d  = RESP;
        result_d = bus.alu_result;
        zero_d   = bus.alu_zero;
        err_d    = 1'b0;
        srca_d   = '0;
        srcb_d   = '0;
        ctrl_d   = '0;
        rsp0_d   = ~owner_q;
        rsp1_d   = owner_q;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rsp0_d  = 1'b0;
          rsp1_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= only; every register, data included, is cleared so outputs are defined after reset.
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      srca_q       <= '0;
      srcb_q       <= '0;
      ctrl_q       <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
      rsp0_q       <= 1'b0;
      rsp1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      srca_q       <= srca_d;
      srcb_q       <= srcb_d;
      ctrl_q       <= ctrl_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      err_q        <= err_d;
      rsp0_q       <= rsp0_d;
      rsp1_q       <= rsp1_d;
      busy_q       <= busy_d;
    end
  end

  // Outputs are forced low for as long as reset is held, not just after the edge.
  assign bus.req0_ready = acc0;
  assign bus.req1_ready = acc1;
  assign bus.rsp0_valid = reset & rsp0_q;
  assign bus.rsp1_valid = reset & rsp1_q;
  assign bus.rsp_result = {WIDTH{reset}} & result_q;
  assign bus.rsp_zero   = reset & zero_q;
  assign bus.rsp_err    = reset & err_q;
  assign bus.alu_srca   = {WIDTH{reset}} & srca_q;
  assign bus.alu_srcb   = {WIDTH{reset}} & srcb_q;
  assign bus.alu_ctrl   = {CTRLW{reset}} & ctrl_q;
  assign bus.busy       = reset & busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: accepted ops push hand-computed responses
// into a scoreboard that a separate monitor drains as responses are consumed.
module tb_alu_share_arbiter;
  localparam int W  = 32;
  localparam int CW = 3;

  typedef struct {
    logic         owner;
    logic [W-1:0] result;
    logic         zero;
    logic         err;
  } rsp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_share_if #(.WIDTH(W), .CTRLW(CW)) bus ();
  alu_share_if #(.WIDTH(W), .CTRLW(CW)) bus_fp ();

  alu_share_arbiter #(.WIDTH(W), .CTRLW(CW), .FIXPRIO(1'b0)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  alu_share_arbiter #(.WIDTH(W), .CTRLW(CW), .FIXPRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset), .bus(bus_fp.slave));

  function automatic logic [W-1:0] alu_stub(input logic [CW-1:0] c,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return '0;
    endcase
  endfunction

  assign bus.alu_result    = alu_stub(bus.alu_ctrl, bus.alu_srca, bus.alu_srcb);
  assign bus.alu_zero      = (bus.alu_result == '0);
  assign bus_fp.alu_result = alu_stub(bus_fp.alu_ctrl, bus_fp.alu_srca, bus_fp.alu_srcb);
  assign bus_fp.alu_zero   = (bus_fp.alu_result == '0);

  // The fixed-priority instance sees exactly the same requester traffic.
  assign bus_fp.req0_valid = bus.req0_valid;
  assign bus_fp.req0_a     = bus.req0_a;
  assign bus_fp.req0_b     = bus.req0_b;
  assign bus_fp.req0_ctrl  = bus.req0_ctrl;
  assign bus_fp.req1_valid = bus.req1_valid;
  assign bus_fp.req1_a     = bus.req1_a;
  assign bus_fp.req1_b     = bus.req1_b;
  assign bus_fp.req1_ctrl  = bus.req1_ctrl;
  assign bus_fp.rsp_ready  = bus.rsp_ready;

  int   n_checks = 0;
  int   n_errors = 0;
  rsp_t sb[$];
  logic grant_log[$];
  rsp_t exp0, exp1;
  bit   in_t3  = 1'b0;
  int   fp0_cnt = 0;
  int   fp1_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting on the DUT", name);
  endtask

  // Acceptance monitor: pushes the expected response of whichever op was taken.
  always @(negedge clk) begin
    if (bus.req0_valid && bus.req1_valid)
      check("ready_onehot", {bus.req0_ready, bus.req1_ready} == 2'b11, 1'b0);
    if (bus.req0_valid && bus.req0_ready) begin
      sb.push_back(exp0);
      grant_log.push_back(1'b0);
    end
    if (bus.req1_valid && bus.req1_ready) begin
      sb.push_back(exp1);
      grant_log.push_back(1'b1);
    end
    if (in_t3) begin
      if (bus_fp.req1_ready) fp1_cnt++;
      if (bus_fp.req0_valid && bus_fp.req0_ready) fp0_cnt++;
    end
  end

  // Response monitor: compares each consumed response with the oldest expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (reset && (bus.rsp0_valid || bus.rsp1_valid) && bus.rsp_ready) begin
      check("rsp_onehot", bus.rsp0_valid & bus.rsp1_valid, 1'b0);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp_unexpected: response with result 0x%0h, none expected", bus.rsp_result);
      end else begin
        e = sb.pop_front();
        check("rsp_owner",  bus.rsp1_valid, e.owner);
        check("rsp_result", bus.rsp_result, e.result);
        check("rsp_zero",   bus.rsp_zero,   e.zero);
        check("rsp_err",    bus.rsp_err,    e.err);
      end
    end
  end

  task automatic set_req(input bit port, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [CW-1:0] c, input logic [W-1:0] r,
                         input logic z, input logic e);
    if (!port) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = c; bus.req0_valid = 1'b1;
      exp0 = '{owner: 1'b0, result: r, zero: z, err: e};
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = c; bus.req1_valid = 1'b1;
      exp1 = '{owner: 1'b1, result: r, zero: z, err: e};
    end
  endtask

  task automatic drop_req(input bit port);
    if (!port) bus.req0_valid = 1'b0;
    else       bus.req1_valid = 1'b0;
  endtask

  // Returns the number of whole cycles that passed before ready was seen.
  task automatic wait_ready(input bit port, input int budget, output int waited, output bit ok);
    ok     = 1'b0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((!port && bus.req0_ready) || (port && bus.req1_ready)) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
  endtask

  task automatic issue(input string name, input bit port, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [CW-1:0] c,
                       input logic [W-1:0] r, input logic z, input logic e,
                       output int waited);
    bit ok;
    set_req(port, a, b, c, r, z, e);
    wait_ready(port, 20, waited, ok);
    if (!ok) fail_timeout(name);
    @(posedge clk); #1;
    drop_req(port);
  endtask

  task automatic wait_rsp0(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_timeout(name);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) fail_timeout(name);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                           bus.rsp_zero, bus.rsp_err, bus.busy}, 7'd0);
    check({name, "_result"}, bus.rsp_result, 0);
    check({name, "_alu_ops"}, {bus.alu_srca, bus.alu_srcb}, 0);
    check({name, "_alu_ctrl"}, bus.alu_ctrl, 0);
  endtask

  initial begin
    int waited;
    bit ok;
    logic exp_order [4];
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;

    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
    bus.rsp_ready  = 1'b1;
    exp0 = '{owner: 1'b0, result: '0, zero: 1'b0, err: 1'b0};
    exp1 = '{owner: 1'b1, result: '0, zero: 1'b0, err: 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: lone add on req0, ready in the same cycle, response two cycles later.
    issue("t1_accept", 1'b0, 32'd5, 32'd7, 3'b000, 32'd12, 1'b0, 1'b0, waited);
    check("t1_ready_same_cycle", waited, 0);
    @(negedge clk);
    check("t1_exec_rsp0", bus.rsp0_valid, 1'b0);
    check("t1_exec_alu", {bus.alu_srca, bus.alu_srcb, 29'd0, bus.alu_ctrl},
          {32'd5, 32'd7, 32'd0});
    @(negedge clk);
    check("t1_latency_rsp0", bus.rsp0_valid, 1'b1);
    @(posedge clk); #1;

    // 2: sub on req1 giving zero; rsp0 must never rise.
    issue("t2_accept", 1'b1, 32'd9, 32'd9, 3'b001, 32'd0, 1'b1, 1'b0, waited);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_rsp0_low", bus.rsp0_valid, 1'b0);
    end
    drain("t2_drain");

    // 3: both requesters valid from reset; grants alternate, fixed-priority never serves req1.
    reset = 1'b0;
    set_req(1'b0, 32'd10, 32'd20, 3'b000, 32'd30, 1'b0, 1'b0);
    set_req(1'b1, 32'hFF00, 32'h0FF0, 3'b010, 32'h0F00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    grant_log.delete();
    fp0_cnt = 0;
    fp1_cnt = 0;
    in_t3   = 1'b1;
    reset   = 1'b1;
    for (int i = 0; i < 40 && grant_log.size() < 4; i++) @(posedge clk);
    #1;
    drop_req(1'b0);
    drop_req(1'b1);
    in_t3 = 1'b0;
    if (grant_log.size() < 4) fail_timeout("t3_grants");
    else for (int i = 0; i < 4; i++) check($sformatf("t3_grant%0d", i), grant_log[i], exp_order[i]);
    check("t3_fp_req1_never_ready", fp1_cnt, 0);
    check("t3_fp_req0_served", fp0_cnt >= 2, 1'b1);
    drain("t3_drain");

    // 4: backpressure holds the response; a waiting req1 is taken only afterwards.
    bus.rsp_ready = 1'b0;
    issue("t4_accept", 1'b0, 32'hF0, 32'h0F, 3'b011, 32'hFF, 1'b0, 1'b0, waited);
    set_req(1'b1, 32'd5, 32'd3, 3'b001, 32'd2, 1'b0, 1'b0);
    wait_rsp0("t4_rsp0");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_rsp0", bus.rsp0_valid, 1'b1);
      check("t4_hold_result", bus.rsp_result, 32'hFF);
      check("t4_hold_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    wait_ready(1'b1, 20, waited, ok);
    if (!ok) fail_timeout("t4_req1");
    else check("t4_req1_after_handshake", waited, 1);
    @(posedge clk); #1;
    drop_req(1'b1);
    drain("t4_drain");

    // 5: illegal control code answers one cycle after accept without touching the ALU.
    set_req(1'b0, 32'd3, 32'd4, 3'b101, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    check("t5_alu_ctrl_idle", bus.alu_ctrl, 0);
    @(posedge clk); #1;
    drop_req(1'b0);
    @(negedge clk);
    check("t5_latency_rsp0", bus.rsp0_valid, 1'b1);
    check("t5_alu_ctrl_resp", {bus.alu_ctrl, bus.alu_srca}, 0);
    drain("t5_drain");

    // 6: reset during RESP aborts the op; the first tie afterwards goes to req0.
    bus.rsp_ready = 1'b0;
    issue("t6_accept", 1'b0, 32'd1, 32'd1, 3'b000, 32'd2, 1'b0, 1'b0, waited);
    wait_rsp0("t6_rsp0");
    @(posedge clk); #1;
    set_req(1'b0, 32'd6, 32'd6, 3'b010, 32'd6, 1'b0, 1'b0);
    set_req(1'b1, 32'd8, 32'd2, 3'b001, 32'd6, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("t6_in_reset");
    sb.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("t6_after_edge");
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("t6_first_tie", {bus.req0_ready, bus.req1_ready}, 2'b10);
    @(posedge clk); #1;
    drop_req(1'b0);
    wait_ready(1'b1, 20, waited, ok);
    if (!ok) fail_timeout("t6_req1");
    @(posedge clk); #1;
    drop_req(1'b1);
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
